tile_spawner: RTL and testbench



---
 rtl/game_pkg.sv | 22 ++
 rtl/lfsr16.sv | 16 +
 rtl/tile_spawner.sv | 116 +++++++++++
 tb/tb_tile_spawner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants for the tile spawner and its neighbours.
package game_pkg;

  localparam int TILE_W  = 12;
  localparam int BOARD_N = 4;

  // board[row][col] holds one tile value, 0 = empty
  typedef logic [BOARD_N-1:0][BOARD_N-1:0][TILE_W-1:0] tile_matrix_t;

  typedef enum logic [1:0] {IDLE, SCAN, PROBE, DONE} spawn_state_t;

  localparam logic [15:0]       LFSR_SEED  = 16'hACE1;
  localparam logic [15:0]       LFSR_TAPS  = 16'hB400;
  localparam logic [TILE_W-1:0] SPAWN_TWO  = 12'd2;
  localparam logic [TILE_W-1:0] SPAWN_FOUR = 12'd4;

  // One right-shifting Galois step: feed the shifted-out bit back through the taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock, reseeds on reset.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Step the LFSR every cycle regardless of what the consumer is doing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= lfsr_step(q);
  end

endmodule

// File: rtl/tile_spawner.sv
// Spawns one new tile into an empty cell of the board after a move.
// SCAN counts empty cells one per cycle; PROBE walks from a random start
// cell to the first empty one and writes the spawn value there.
// Optional build macro TILE_SPAWNER_FOUR_EN: spawn a 4 instead of a 2 when
// lfsr[6:4] is all ones at the write cycle (about 1 in 8 spawns).
module tile_spawner
  import game_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         moved,
  input  tile_matrix_t matrix_in,
  output tile_matrix_t matrix_out,
  output logic         busy,
  output logic         done,
  output logic         full
);

  spawn_state_t      state, state_n;
  tile_matrix_t      board;
  logic [4:0]        cnt;
  logic [4:0]        cnt_sum;
  logic [3:0]        idx;
  logic [3:0]        ptr;
  logic              moved_q;
  logic [15:0]       lfsr;
  logic              scan_zero;
  logic              probe_zero;
  logic [TILE_W-1:0] spawn_val;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign scan_zero  = (board[idx[3:2]][idx[1:0]] == '0);
  assign probe_zero = (board[ptr[3:2]][ptr[1:0]] == '0);
  // count including the cell being scanned this cycle, so cell 15 is seen
  assign cnt_sum    = cnt + {4'd0, scan_zero};
  assign busy       = (state != IDLE);

`ifdef TILE_SPAWNER_FOUR_EN
  assign spawn_val = (lfsr[6:4] == 3'b111) ? SPAWN_FOUR : SPAWN_TWO;
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[15:7];
`else
  assign spawn_val = SPAWN_TWO;
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[15:4];
`endif

  // State register; reset abandons any pass in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: full scan of 16 cells, then probe only if a spawn is needed.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = SCAN;
      SCAN:  if (idx == 4'd15)
               state_n = (cnt_sum == 5'd0 || !moved_q) ? DONE : PROBE;
      PROBE: if (probe_zero) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latch the board, count empties, probe and write, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board      <= '0;
      matrix_out <= '0;
      cnt        <= '0;
      idx        <= '0;
      ptr        <= '0;
      moved_q    <= 1'b0;
      full       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          board   <= matrix_in;
          moved_q <= moved;
          full    <= 1'b0;
          cnt     <= '0;
          idx     <= '0;
        end
        SCAN: begin
          cnt <= cnt_sum;
          idx <= idx + 4'd1;
          if (idx == 4'd15) begin
            if (cnt_sum == 5'd0)  full <= 1'b1;
            else if (moved_q)     ptr  <= lfsr[3:0];
          end
        end
        PROBE: begin
          // nonzero count guarantees an empty cell within 16 steps
          if (probe_zero) board[ptr[3:2]][ptr[1:0]] <= spawn_val;
          else            ptr <= ptr + 4'd1;
        end
        DONE: begin
          done       <= 1'b1;
          matrix_out <= board;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: table of boards plus reset, double-start and burst sequences.
module tb_tile_spawner;
  import game_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         moved = 1'b0;
  tile_matrix_t matrix_in = '0;
  tile_matrix_t matrix_out;
  logic         busy, done, full;

  always #5 clk = ~clk;

  tile_spawner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .moved      (moved),
    .matrix_in  (matrix_in),
    .matrix_out (matrix_out),
    .busy       (busy),
    .done       (done),
    .full       (full)
  );

  // Reference LFSR built from the published taps/seed, sharing the reset.
  logic [15:0] mdl;
  always @(posedge clk or posedge rst) begin
    if (rst)         mdl <= 16'hACE1;
    else if (mdl[0]) mdl <= (mdl >> 1) ^ 16'hB400;
    else             mdl <= mdl >> 1;
  end

  int passed = 0;
  int total  = 0;
  logic [15:0] hist [0:63];

  typedef struct {
    tile_matrix_t b;
    logic         mv;
    logic         exp_full;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic tile_matrix_t fill(input logic [11:0] v);
    tile_matrix_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = v;
    return m;
  endfunction

  function automatic logic [11:0] spawn_of(input logic [15:0] h);
`ifdef TILE_SPAWNER_FOUR_EN
    return (h[6:4] == 3'b111) ? 12'd4 : 12'd2;
`else
    return 12'd2;
`endif
  endfunction

  // One pass: start at edge 0, scramble inputs afterwards, optionally pulse a second start.
  // lat = edges after the start edge until done is seen; hist[L] = LFSR between edges L and L+1.
  task automatic run_pass(input tile_matrix_t b, input logic mv, input int extra_at, output int lat);
    @(negedge clk); matrix_in = b; moved = mv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; moved = ~mv;
    matrix_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    lat = 0; hist[0] = mdl;
    while (!done && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk); hist[lat] = mdl;
      start = (lat == extra_at);
    end
    start = 1'b0;
  endtask

  // Expected result from the captured LFSR history.
  task automatic expect_pass(input tile_matrix_t b, input logic mv,
                             output tile_matrix_t eb, output logic ef, output int elat);
    int nz; int p; int id; logic found;
    nz = 0; eb = b; ef = 1'b0; elat = 17; found = 1'b0;
    for (int i = 0; i < 16; i++) if (b[i/4][i%4] == 12'd0) nz++;
    if (nz == 0) ef = 1'b1;
    else if (mv) begin
      p = int'(hist[15][3:0]);
      for (int j = 0; j < 16; j++) begin
        id = (p + j) % 16;
        if (!found && b[id/4][id%4] == 12'd0) begin
          found = 1'b1;
          eb[id/4][id%4] = spawn_of(hist[16 + j]);
          elat = 18 + j;
        end
      end
    end
  endtask

  initial begin
    int lat, elat, fours, errs, extra;
    tile_matrix_t eb, tmp;
    logic ef;

    // table: board, moved, expected full
    vt[0].b = fill(12'd0);  vt[0].mv = 1'b1; vt[0].exp_full = 1'b0;
    tmp = fill(12'd2); tmp[2][1] = 12'd0;
    vt[1].b = tmp;          vt[1].mv = 1'b1; vt[1].exp_full = 1'b0;
    for (int i = 0; i < 16; i++) tmp[i/4][i%4] = 12'(2 << (i % 11));
    vt[2].b = tmp;          vt[2].mv = 1'b1; vt[2].exp_full = 1'b1;
    vt[3].b = fill(12'd0);  vt[3].mv = 1'b0; vt[3].exp_full = 1'b0;
    vt[4].b = tmp;          vt[4].mv = 1'b0; vt[4].exp_full = 1'b1;
    tmp = fill(12'd8); tmp[3][3] = 12'd0;
    vt[5].b = tmp;          vt[5].mv = 1'b1; vt[5].exp_full = 1'b0;
    tmp = fill(12'd16); tmp[0][0] = 12'd0;
    vt[6].b = tmp;          vt[6].mv = 1'b1; vt[6].exp_full = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out",  matrix_out, '0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_pass(vt[v].b, vt[v].mv, -1, lat);
      expect_pass(vt[v].b, vt[v].mv, eb, ef, elat);
      chk($sformatf("v%0d_lat", v), lat, elat);
      chk($sformatf("v%0d_full", v), full, vt[v].exp_full);
      chk($sformatf("v%0d_full_model", v), ef, vt[v].exp_full);
      chk($sformatf("v%0d_out", v), matrix_out, eb);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_hold", v), matrix_out, eb);
    end

    // reset in the middle of SCAN
    @(negedge clk); matrix_in = fill(12'd0); moved = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b1; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_out", matrix_out, '0);
    @(negedge clk); rst = 1'b0;
    run_pass(fill(12'd0), 1'b1, -1, lat);
    expect_pass(fill(12'd0), 1'b1, eb, ef, elat);
    chk("after_rst_lat", lat, elat);
    chk("after_rst_out", matrix_out, eb);

    // second start while busy must be ignored
    tmp = fill(12'd2); tmp[1][1] = 12'd0;
    run_pass(tmp, 1'b1, 5, lat);
    expect_pass(tmp, 1'b1, eb, ef, elat);
    chk("dbl_lat", lat, elat);
    chk("dbl_out", matrix_out, eb);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("dbl_single_done", extra, 0);
    chk("dbl_idle", busy, 0);

    // burst of passes: exact value/location each pass, 4-valued spawns tallied
    fours = 0; errs = 0;
    for (int n = 0; n < 1000; n++) begin
      run_pass(fill(12'd0), 1'b1, -1, lat);
      expect_pass(fill(12'd0), 1'b1, eb, ef, elat);
      if (lat != elat || matrix_out !== eb) errs++;
      for (int i = 0; i < 16; i++) if (matrix_out[i/4][i%4] == 12'd4) fours++;
    end
    chk("burst_errs", errs, 0);
`ifdef TILE_SPAWNER_FOUR_EN
    chk("burst_four_ratio", (fours >= 50 && fours <= 250), 1);
`else
    chk("burst_no_four", fours, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
